// File: rtl/cache_bus_pkg.sv
// rtl/cache_bus_pkg.sv - shared types and constants for the cache bus arbiter
//
// Purpose: FSM state encoding, requester/bus widths and a one-hot helper
//          shared by cache_bus_arbiter and rr_arbiter.
// Ports:   none (package).
package cache_bus_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int CNT_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin one-hot picker
//
// Purpose: picks the first asserted request scanning from last_winner+1
//          upward (mod NUM_REQ), so the previous owner has lowest priority.
// Ports:
//   req          in  [NUM_REQ-1:0]  pending requests
//   last_winner  in  [IDX_W-1:0]    index of the previous owner
//   grant        out [NUM_REQ-1:0]  one-hot winner, zero when no request
//   winner       out [IDX_W-1:0]    index of the winner (last_winner if none)
//   valid        out                at least one request pending
module rr_arbiter
  import cache_bus_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_winner,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    grant  = '0;
    winner = last_winner;
    valid  = 1'b0;
    idx    = '0;
    // Offsets 1..NUM_REQ; the 2-bit add wraps modulo NUM_REQ, and offset
    // NUM_REQ revisits last_winner itself as the lowest-priority candidate.
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = last_winner + IDX_W'(i);
      if (!valid && req[idx]) begin
        valid      = 1'b1;
        winner     = idx;
        grant      = idx_to_onehot(idx);
      end
    end
  end

endmodule

// File: rtl/cache_bus_arbiter.sv
// rtl/cache_bus_arbiter.sv - four-requester arbiter in front of a single-bus cache controller
//
// Purpose: grants the cache bus to one requester at a time (round-robin),
//          launches one bus transaction, waits for finish or timeout and
//          returns a done pulse with read data / error.
// Ports:
//   clk           in        rising-edge clock
//   rst           in        asynchronous active-low reset
//   req           in  [3:0] per-requester request level
//   req_read_op   in  [3:0] per-requester op (1 = read, 0 = write)
//   req_address   in  [31:0] packed 8-bit addresses, requester i at [8i+7:8i]
//   req_data      in  [31:0] packed 8-bit write data, same packing
//   grant         out [3:0] one-hot bus owner, zero when idle
//   done          out [3:0] one-cycle completion pulse to the owner
//   rd_data       out [7:0] read data, valid in the done cycle
//   err           out       timeout flag, held until the next completion
//   bus_start     out       one-cycle start to the cache controller
//   bus_read_op   out       op to the cache controller
//   bus_address   out [7:0] address to the cache controller
//   bus_data      out [7:0] write data to the cache controller
//   bus_out_data  in  [7:0] read data from the cache controller
//   bus_finish    in        cache controller finish flag
module cache_bus_arbiter
  import cache_bus_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         req_read_op,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_address,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         done,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       err,
  output logic                       bus_start,
  output logic                       bus_read_op,
  output logic [ADDR_W-1:0]          bus_address,
  output logic [DATA_W-1:0]          bus_data,
  input  logic [DATA_W-1:0]          bus_out_data,
  input  logic                       bus_finish
);

  // Last WAIT cycle index before abort: WAIT lasts at most TIMEOUT cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]     winner_q, winner_d;
  logic [IDX_W-1:0]     last_winner_q, last_winner_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]    rd_data_q, rd_data_d;
  logic                 err_q, err_d;
  logic                 bus_read_op_q, bus_read_op_d;
  logic [ADDR_W-1:0]    bus_address_q, bus_address_d;
  logic [DATA_W-1:0]    bus_data_q, bus_data_d;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [IDX_W-1:0]     arb_winner;
  logic                 arb_valid;

  rr_arbiter u_rr_arbiter (
    .req         (req),
    .last_winner (last_winner_q),
    .grant       (arb_grant),
    .winner      (arb_winner),
    .valid       (arb_valid)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      winner_q      <= '0;
      last_winner_q <= IDX_W'(NUM_REQ - 1);
      cnt_q         <= '0;
      rd_data_q     <= '0;
      err_q         <= 1'b0;
      bus_read_op_q <= 1'b1;
      bus_address_q <= '0;
      bus_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      winner_q      <= winner_d;
      last_winner_q <= last_winner_d;
      cnt_q         <= cnt_d;
      rd_data_q     <= rd_data_d;
      err_q         <= err_d;
      bus_read_op_q <= bus_read_op_d;
      bus_address_q <= bus_address_d;
      bus_data_q    <= bus_data_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    winner_d      = winner_q;
    last_winner_d = last_winner_q;
    cnt_d         = '0;
    rd_data_d     = rd_data_q;
    err_d         = err_q;
    bus_read_op_d = bus_read_op_q;
    bus_address_d = bus_address_q;
    bus_data_d    = bus_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d  = ST_ISSUE;
          grant_d  = arb_grant;
          winner_d = arb_winner;
          // Requester fields are captured only here and held until RESP.
          for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
              bus_read_op_d = req_read_op[i];
              bus_address_d = req_address[i*ADDR_W +: ADDR_W];
              bus_data_d    = req_data[i*DATA_W +: DATA_W];
            end
          end
        end
      end

      ST_ISSUE: begin
        // bus_finish is deliberately not looked at here (stale finish).
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        // Completion is checked first so it beats a coincident timeout.
        if (bus_finish) begin
          state_d = ST_RESP;
          err_d   = 1'b0;
          if (bus_read_op_q) begin
            rd_data_d = bus_out_data;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RESP: begin
        state_d       = ST_IDLE;
        grant_d       = '0;
        last_winner_d = winner_q;
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Outputs
  always_comb begin
    bus_start   = (state_q == ST_ISSUE);
    done        = (state_q == ST_RESP) ? grant_q : '0;
    grant       = grant_q;
    rd_data     = rd_data_q;
    err         = err_q;
    bus_read_op = bus_read_op_q;
    bus_address = bus_address_q;
    bus_data    = bus_data_q;
  end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// tb/tb_cache_bus_arbiter.sv - self-checking bench for cache_bus_arbiter
module tb_cache_bus_arbiter;

  localparam int TO = 8;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  req_read_op;
  logic [31:0] req_address;
  logic [31:0] req_data;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic [7:0]  rd_data;
  logic        err;
  logic        bus_start;
  logic        bus_read_op;
  logic [7:0]  bus_address;
  logic [7:0]  bus_data;
  logic [7:0]  bus_out_data;
  logic        bus_finish;

  int tests_run;
  int tests_failed;

  // Reference model state
  int         model_last;
  logic [7:0] model_rd;
  logic       model_err;

  cache_bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_read_op  (req_read_op),
    .req_address  (req_address),
    .req_data     (req_data),
    .grant        (grant),
    .done         (done),
    .rd_data      (rd_data),
    .err          (err),
    .bus_start    (bus_start),
    .bus_read_op  (bus_read_op),
    .bus_address  (bus_address),
    .bus_data     (bus_data),
    .bus_out_data (bus_out_data),
    .bus_finish   (bus_finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_grant"},     32'(grant),       32'h0);
    check_eq({pfx, "_done"},      32'(done),        32'h0);
    check_eq({pfx, "_bus_start"}, 32'(bus_start),   32'h0);
    check_eq({pfx, "_err"},       32'(err),         32'h0);
    check_eq({pfx, "_rd_data"},   32'(rd_data),     32'h0);
    check_eq({pfx, "_read_op"},   32'(bus_read_op), 32'h1);
    check_eq({pfx, "_address"},   32'(bus_address), 32'h0);
    check_eq({pfx, "_data"},      32'(bus_data),    32'h0);
  endtask

  // One full transaction starting at a falling edge in IDLE. fin_k is the
  // WAIT cycle (0-based) in which bus_finish is raised; negative or >= TO
  // means the controller never answers. stale raises bus_finish already
  // during IDLE/ISSUE. hold_req keeps req steady, otherwise it is scrambled
  // after the grant to show inputs are not re-sampled.
  task automatic do_txn(input logic [3:0] rq, input logic [3:0] ops,
                        input logic [31:0] addrs, input logic [31:0] datas,
                        input int fin_k, input logic [7:0] od,
                        input bit stale, input bit hold_req);
    int         w;
    int         last_k;
    bit         timed;
    logic [3:0] oh;
    logic [7:0] exp_addr;
    logic [7:0] exp_data;

    check_eq("idle_grant", 32'(grant), 32'h0);
    check_eq("idle_done",  32'(done),  32'h0);
    check_eq("idle_start", 32'(bus_start), 32'h0);

    w = -1;
    for (int i = 1; i <= 4; i++) begin
      int j;
      j = (model_last + i) % 4;
      if (w < 0 && rq[j]) w = j;
    end
    oh       = 4'b0001 << w;
    exp_addr = addrs[8*w +: 8];
    exp_data = datas[8*w +: 8];
    timed    = !(fin_k >= 0 && fin_k < TO);
    last_k   = timed ? TO - 1 : fin_k;

    req          = rq;
    req_read_op  = ops;
    req_address  = addrs;
    req_data     = datas;
    bus_finish   = stale;
    bus_out_data = 8'($urandom);

    @(negedge clk);
    check_eq("issue_start",   32'(bus_start),   32'h1);
    check_eq("issue_grant",   32'(grant),       32'(oh));
    check_eq("issue_done",    32'(done),        32'h0);
    check_eq("issue_addr",    32'(bus_address), 32'(exp_addr));
    check_eq("issue_data",    32'(bus_data),    32'(exp_data));
    check_eq("issue_read_op", 32'(bus_read_op), 32'(ops[w]));
    if (!hold_req) req = 4'($urandom);
    req_address = $urandom;
    req_data    = $urandom;
    req_read_op = 4'($urandom);

    for (int k = 0; k <= last_k; k++) begin
      @(negedge clk);
      check_eq("wait_start", 32'(bus_start),   32'h0);
      check_eq("wait_done",  32'(done),        32'h0);
      check_eq("wait_grant", 32'(grant),       32'(oh));
      check_eq("wait_addr",  32'(bus_address), 32'(exp_addr));
      check_eq("wait_data",  32'(bus_data),    32'(exp_data));
      bus_finish   = (k == fin_k);
      bus_out_data = (k == fin_k) ? od : 8'($urandom);
    end

    if (!timed && ops[w]) model_rd = od;
    model_err  = timed;
    model_last = w;

    @(negedge clk);
    check_eq("resp_done",    32'(done),      32'(oh));
    check_eq("resp_err",     32'(err),       32'(model_err));
    check_eq("resp_rd_data", 32'(rd_data),   32'(model_rd));
    check_eq("resp_start",   32'(bus_start), 32'h0);
    bus_finish = 1'b0;
    if (!hold_req) req = 4'h0;

    @(negedge clk);
    check_eq("post_done", 32'(done),  32'h0);
    check_eq("post_err",  32'(err),   32'(model_err));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    model_last   = 3;
    model_rd     = 8'h00;
    model_err    = 1'b0;

    rst          = 1'b0;
    req          = 4'h0;
    req_read_op  = 4'h0;
    req_address  = 32'h0;
    req_data     = 32'h0;
    bus_out_data = 8'h0;
    bus_finish   = 1'b0;

    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b1;
    @(negedge clk);

    // Fairness: all four requesting, finish 3 cycles after bus_start.
    for (int n = 0; n < 5; n++) begin
      do_txn(4'b1111, 4'b1010, 32'h44332211, 32'h88776655, 2, 8'(8'h30 + n), 1'b0, 1'b1);
    end
    req = 4'h0;

    // Single read: finish 4 cycles after bus_start with 0xA5.
    do_txn(4'b0001, 4'b0001, 32'h00000001, 32'h0, 3, 8'hA5, 1'b0, 1'b0);
    // Write from requester 2; rd_data must stay 0xA5.
    do_txn(4'b0100, 4'b0000, 32'h00050000, 32'h000B0000, 1, 8'h5A, 1'b0, 1'b0);
    // Timeout, then a good read clears err.
    do_txn(4'b0010, 4'b0010, 32'h00007700, 32'h0, -1, 8'h00, 1'b0, 1'b0);
    do_txn(4'b1000, 4'b1000, 32'h12000000, 32'h0, 0, 8'h3C, 1'b0, 1'b0);
    // Finish coincident with the timeout cycle: completion wins.
    do_txn(4'b0001, 4'b0001, 32'h00000042, 32'h0, TO - 1, 8'hC3, 1'b0, 1'b0);
    // Stale finish held across ISSUE.
    do_txn(4'b0100, 4'b0100, 32'h00090000, 32'h0, 0, 8'h7E, 1'b1, 1'b0);

    // Reset in the middle of WAIT.
    req         = 4'b1000;
    req_read_op = 4'b1000;
    req_address = 32'hAB000000;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    req = 4'h0;
    @(negedge clk);
    check_eq("midrst_done_hold", 32'(done), 32'h0);
    rst = 1'b1;
    model_last = 3;
    model_rd   = 8'h00;
    model_err  = 1'b0;
    @(negedge clk);
    check_eq("midrst_no_done", 32'(done), 32'h0);
    do_txn(4'b0010, 4'b0010, 32'h0000CD00, 32'h0, 2, 8'h99, 1'b0, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      int fk;
      fk = int'($urandom_range(0, 10)) - 1;
      do_txn(4'($urandom_range(1, 15)), 4'($urandom), $urandom, $urandom,
             fk, 8'($urandom), (fk == 0) && $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1);
    end
    req = 4'h0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cache_bus_arbiter.md
CACHE_BUS_ARBITER -- requirements
Module: cache_bus_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 64, bus cycles allowed in WAIT before abort (legal range 1..255).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-low.
REQ-004 Port: req  input  4  per-requester transaction request, level, held until own done.
REQ-005 Port: req_read_op  input  4  per-requester op: 1 = read, 0 = write.
REQ-006 Port: req_address  input  32  four packed 8-bit addresses, requester i at bits [8i+7:8i].
REQ-007 Port: req_data  input  32  four packed 8-bit write data, same packing.
REQ-008 Port: grant  output  4  one-hot owner of the cache bus, all-zero when idle.
REQ-009 Port: done  output  4  one-cycle completion pulse to the owning requester.
REQ-010 Port: rd_data  output  8  read data returned, valid in the done cycle.
REQ-011 Port: err  output  1  asserted with done when the transaction timed out.
REQ-012 Port: bus_start  output  1  one-cycle start to the single-bus cache controller.
REQ-013 Port: bus_read_op, bus_address, bus_data  output  1/8/8  op, address, write data to the cache controller.
REQ-014 Port: bus_out_data  input  8  read data from the cache controller.
REQ-015 Port: bus_finish  input  1  cache controller finish flag.

Function
REQ-016 States: IDLE, ISSUE, WAIT, RESP; exactly one active.
REQ-017 IDLE: if req != 0, select winner by round-robin starting at last_winner+1 mod 4, go ISSUE; else stay.
REQ-018 On IDLE->ISSUE edge: latch winner's read_op/address/data into bus_read_op/bus_address/bus_data, set grant one-hot to the winner.
REQ-019 ISSUE: bus_start = 1 for exactly this one cycle; go WAIT unconditionally.
REQ-020 bus_address/bus_read_op/bus_data stay constant from ISSUE through RESP; requester inputs are not re-sampled.
REQ-021 WAIT: bus_finish sampled only here; bus_finish high in the ISSUE cycle is ignored.
REQ-022 WAIT with bus_finish = 1: rd_data <= bus_out_data if read (unchanged if write), err <= 0, go RESP.
REQ-023 WAIT: 8-bit counter starts at 0 on entry, increments each cycle; reaching TIMEOUT without bus_finish: err <= 1, rd_data unchanged, go RESP.
REQ-024 bus_finish and timeout in the same cycle: completion wins, err = 0.
REQ-025 RESP: done[winner] = 1 for one cycle, err valid; last_winner <= winner; grant cleared at exit; go IDLE.
REQ-026 Latency: req seen in IDLE at cycle 0 -> bus_start at cycle 1 -> finish at cycle N (N >= 2) -> done at N+1 -> IDLE at N+2.
REQ-027 Requests arriving during ISSUE/WAIT/RESP are ignored until IDLE; no back-to-back grant without one IDLE cycle.
REQ-028 Requester dropping req mid-transaction: transaction still completes and done still pulses.
REQ-029 Simultaneous requests: only the round-robin winner is granted; others wait; no requester starves beyond 3 other transactions.
REQ-030 err is held between transactions; cleared only by next completion or reset.

Reset
REQ-031 On rst low (any state, mid-transaction included): state = IDLE, grant = 0, done = 0, bus_start = 0, err = 0, rd_data = 0, bus_read_op = 1, bus_address = 0, bus_data = 0, counter = 0, last_winner = 3 (requester 0 wins first).
REQ-032 A transaction aborted by reset produces no done pulse.

Structure
REQ-033 Shared package cache_bus_pkg: state enum, NUM_REQ = 4, ADDR_W = 8, DATA_W = 8.
REQ-034 One sub-module: rr_arbiter (combinational one-hot picker from req and last_winner); the FSM, latches and counter stay in cache_bus_arbiter.

Verification
REQ-035 Single read: req = 0001, addr0 = 0x01, read; bus_finish 4 cycles after bus_start with bus_out_data = 0xA5 -> bus_start one cycle, done = 0001, rd_data = 0xA5, err = 0.
REQ-036 Write: req = 0100, addr2 = 0x05, data2 = 0x0B, write -> bus_address = 0x05, bus_data = 0x0B, bus_read_op = 0; after finish done = 0100, rd_data unchanged.
REQ-037 Fairness: req = 1111 held, each finish after 3 cycles -> grants in order 0001, 0010, 0100, 1000, 0001.
REQ-038 Timeout: TIMEOUT = 8, never assert bus_finish -> done after 8 WAIT cycles with err = 1; next good transaction clears err.
REQ-039 Reset mid-WAIT: rst low for 1 cycle -> all outputs at reset values, no done; then req = 0010 -> requester 1 granted.
REQ-040 Stale finish: bus_finish held high across ISSUE -> not accepted in ISSUE; accepted in first WAIT cycle, done one cycle later.
